// File: rtl/vec_pkg.sv
// vec_pkg
// Shared definitions for the vector operand path: the vector and element
// geometry, the vector type handed to alu_vec, and the state encoding of
// the operand loader.
// No ports (package).
package vec_pkg;

  localparam int VEC_SIZE = 256;
  localparam int ELEM     = 16;
  localparam int N_ELEM   = VEC_SIZE / ELEM;
  localparam int ADDR_W   = 16;

  typedef logic [VEC_SIZE-1:0] vec_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    WAIT,
    DONE
  } loader_state_t;

endpackage

// File: rtl/vec_operand_loader.sv
// vec_operand_loader
// Operand-fetch stage in front of alu_vec. On start it reads N elements of
// vector A and then N elements of vector B, one per cycle, from a
// synchronous element-wide memory. It assembles both vectors and presents
// them with the latched opcode under a valid/ready handshake.
// Ports:
//   clk, rst_n          clock (rising edge) and async active-low reset
//   start               load request, only honoured in IDLE
//   base_a, base_b      element addresses of A[0] and B[0]
//   opcode_in           opcode latched with the accepted start
//   busy                high whenever the loader is not IDLE
//   mem_rd_en/mem_addr  read strobe and address towards the memory
//   mem_rdata           read data, valid one cycle after mem_rd_en
//   vectorA, vectorB    assembled vectors, element 0 in the LSBs
//   opcode              latched opcode
//   out_valid/out_ready result handshake towards the ALU/writeback
module vec_operand_loader
  import vec_pkg::*;
#(
  parameter int vector_size = VEC_SIZE,
  parameter int element     = ELEM,
  parameter int addr_width  = ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [addr_width-1:0]  base_a,
  input  logic [addr_width-1:0]  base_b,
  input  logic [2:0]             opcode_in,
  output logic                   busy,
  output logic                   mem_rd_en,
  output logic [addr_width-1:0]  mem_addr,
  input  logic [element-1:0]     mem_rdata,
  output logic [vector_size-1:0] vectorA,
  output logic [vector_size-1:0] vectorB,
  output logic [2:0]             opcode,
  output logic                   out_valid,
  input  logic                   out_ready
);

  localparam int NE    = vector_size / element;
  localparam int CNT_W = $clog2(2 * NE);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(2 * NE - 1);
  localparam logic [CNT_W-1:0] NE_CNT   = CNT_W'(NE);

  loader_state_t          state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [addr_width-1:0]  baseA_q, baseA_d;
  logic [addr_width-1:0]  baseB_q, baseB_d;
  logic [2:0]             opcode_q, opcode_d;
  logic                   capEn_q, capEn_d;
  logic [CNT_W-1:0]       capIdx_q, capIdx_d;
  logic [vector_size-1:0] vecA_q, vecA_d;
  logic [vector_size-1:0] vecB_q, vecB_d;
  logic [CNT_W-1:0]       offset;
  logic [CNT_W-1:0]       slot;

  // State register plus every datapath register; reset clears all of them
  // so an aborted load never leaves a partial vector visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      baseA_q  <= '0;
      baseB_q  <= '0;
      opcode_q <= '0;
      capEn_q  <= 1'b0;
      capIdx_q <= '0;
      vecA_q   <= '0;
      vecB_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      baseA_q  <= baseA_d;
      baseB_q  <= baseB_d;
      opcode_q <= opcode_d;
      capEn_q  <= capEn_d;
      capIdx_q <= capIdx_d;
      vecA_q   <= vecA_d;
      vecB_q   <= vecB_d;
    end
  end

  // Next-state logic and memory-side outputs. The issue counter walks
  // 0..2N-1: the low half addresses A, the high half addresses B. Address
  // arithmetic is plain modulo-2^addr_width, so a base near the top wraps.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    baseA_d   = baseA_q;
    baseB_d   = baseB_q;
    opcode_d  = opcode_q;
    mem_rd_en = 1'b0;
    mem_addr  = '0;
    out_valid = 1'b0;
    offset    = (cnt_q < NE_CNT) ? cnt_q : (cnt_q - NE_CNT);

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = FETCH;
          cnt_d    = '0;
          baseA_d  = base_a;
          baseB_d  = base_b;
          opcode_d = opcode_in;
        end
      end
      FETCH: begin
        mem_rd_en = 1'b1;
        mem_addr  = ((cnt_q < NE_CNT) ? baseA_q : baseB_q) + addr_width'(offset);
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        // The final B element lands on this edge via the capture pipe.
        state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    capEn_d  = mem_rd_en;
    capIdx_d = cnt_q;
  end

  // Slot-write decoders: the delayed (rd_en, cnt) pair names the element
  // whose data is on mem_rdata this cycle; data arriving without a
  // preceding read strobe is dropped.
  always_comb begin
    vecA_d = vecA_q;
    vecB_d = vecB_q;
    slot   = '0;
    if (capEn_q) begin
      if (capIdx_q < NE_CNT) begin
        slot = capIdx_q;
        vecA_d[slot*element +: element] = mem_rdata;
      end else begin
        slot = capIdx_q - NE_CNT;
        vecB_d[slot*element +: element] = mem_rdata;
      end
    end
  end

  assign busy    = (state_q != IDLE);
  assign vectorA = vecA_q;
  assign vectorB = vecB_q;
  assign opcode  = opcode_q;

endmodule

// File: tb/tb_vec_operand_loader.sv
// tb_vec_operand_loader
// Drives vec_operand_loader against a synchronous memory model filled with
// random data, and compares each load with vectors and address sequences
// computed directly from the memory contents and the base addresses.
module tb_vec_operand_loader;
  import vec_pkg::*;

  localparam int N = N_ELEM;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [15:0]   base_a, base_b;
  logic [2:0]    opcode_in;
  logic          busy;
  logic          mem_rd_en;
  logic [15:0]   mem_addr;
  logic [15:0]   mem_rdata;
  logic [255:0]  vectorA, vectorB;
  logic [2:0]    opcode;
  logic          out_valid;
  logic          out_ready;

  logic [15:0]   mem [0:65535];

  int vectorsApplied = 0;
  int miscompares    = 0;

  vec_operand_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_a(base_a), .base_b(base_b),
    .opcode_in(opcode_in), .busy(busy), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .vectorA(vectorA), .vectorB(vectorB), .opcode(opcode),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  // Synchronous memory: data one cycle after the strobe, garbage otherwise
  // so that captures without a strobe show up as wrong elements.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
    else           mem_rdata <= 16'($urandom);
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [255:0] observed,
                             input logic [255:0] expected);
    vectorsApplied++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Reference vector: element i is whatever memory holds at base+i (mod 2^16).
  function automatic vec_t modelVec(input logic [15:0] base);
    vec_t v;
    for (int i = 0; i < N; i++) v[i*16 +: 16] = mem[base + 16'(i)];
    return v;
  endfunction

  // All outputs must read zero while / right after reset is applied.
  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_rden"}, mem_rd_en, 0);
    checkOutput({tag, "_valid"}, out_valid, 0);
    checkOutput({tag, "_addr"}, mem_addr, 0);
    checkOutput({tag, "_opcode"}, opcode, 0);
    checkOutput({tag, "_vecA"}, vectorA, 0);
    checkOutput({tag, "_vecB"}, vectorB, 0);
  endtask

  // One complete load: start, collect issued addresses, check latency and
  // result, hold out_ready low for a while, then handshake.
  task automatic applyStimulus(input logic [15:0] ba, input logic [15:0] bb,
                               input logic [2:0] op, input int holdCycles,
                               input bit midStart);
    vec_t        expA, expB;
    logic [15:0] expAddr[$];
    logic [15:0] gotAddr[$];
    int          cycles;
    bit          seen;
    expA = modelVec(ba);
    expB = modelVec(bb);
    for (int i = 0; i < N; i++) expAddr.push_back(ba + 16'(i));
    for (int i = 0; i < N; i++) expAddr.push_back(bb + 16'(i));

    @(negedge clk);
    checkOutput("idle_before_start", busy, 0);
    start = 1'b1; base_a = ba; base_b = bb; opcode_in = op; out_ready = 1'b0;
    cycles = 0;
    seen = 1'b0;
    // Negedge number k lies between edges E0+k-1 and E0+k.
    while (!seen && cycles < 200) begin
      @(negedge clk);
      cycles++;
      start = 1'b0;
      if (mem_rd_en) gotAddr.push_back(mem_addr);
      if (out_valid) seen = 1'b1;
      else if (midStart && cycles == 9) begin
        start = 1'b1; base_a = ~ba; base_b = ~bb; opcode_in = ~op;
      end
    end
    start = 1'b0;
    if (!seen) begin
      checkOutput("valid_timeout", 0, 1);
      return;
    end
    checkOutput("valid_latency_edges", cycles - 1, 2 * N + 1);
    checkOutput("rd_count", gotAddr.size(), 2 * N);
    for (int i = 0; i < gotAddr.size() && i < 2 * N; i++)
      checkOutput($sformatf("addr%0d", i), gotAddr[i], expAddr[i]);
    checkOutput("vectorA", vectorA, expA);
    checkOutput("vectorB", vectorB, expB);
    checkOutput("opcode", opcode, op);
    checkOutput("busy_done", busy, 1);
    for (int h = 0; h < holdCycles; h++) begin
      @(negedge clk);
      checkOutput($sformatf("hold%0d_valid", h), out_valid, 1);
      checkOutput($sformatf("hold%0d_vecA", h), vectorA, expA);
      checkOutput($sformatf("hold%0d_vecB", h), vectorB, expB);
      checkOutput($sformatf("hold%0d_op", h), opcode, op);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("post_hs_valid", out_valid, 0);
    checkOutput("post_hs_idle", busy, 0);
    checkOutput("post_hs_vecA_kept", vectorA, expA);
    out_ready = 1'b0;
  endtask

  // Reset asserted at cycle 10 of FETCH must clear everything at once.
  task automatic resetMidFetch(input logic [15:0] ba, input logic [15:0] bb);
    @(negedge clk);
    start = 1'b1; base_a = ba; base_b = bb; opcode_in = 3'b101; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    checkOutput("pre_reset_rden", mem_rd_en, 1);
    rst_n = 1'b0;
    #1;
    checkResetOutputs("midfetch_reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Start and out_ready held high: two loads must run back to back.
  task automatic backToBack(input logic [15:0] ba, input logic [15:0] bb);
    vec_t expA, expB;
    int   validAt[$];
    int   firstRdAfter;
    expA = modelVec(ba);
    expB = modelVec(bb);
    firstRdAfter = -1;
    @(negedge clk);
    start = 1'b1; base_a = ba; base_b = bb; opcode_in = 3'b110; out_ready = 1'b1;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      @(negedge clk);
      if (out_valid) begin
        validAt.push_back(cyc);
        checkOutput($sformatf("b2b%0d_vecA", validAt.size()), vectorA, expA);
        checkOutput($sformatf("b2b%0d_vecB", validAt.size()), vectorB, expB);
      end
      if (validAt.size() == 1 && firstRdAfter < 0 && mem_rd_en) firstRdAfter = cyc;
    end
    start = 1'b0;
    out_ready = 1'b0;
    checkOutput("b2b_two_pulses", validAt.size() >= 2, 1);
    if (validAt.size() >= 2) begin
      checkOutput("b2b_spacing", validAt[1] - validAt[0], 2 * N + 3);
      checkOutput("b2b_refetch_gap", firstRdAfter - validAt[0], 2);
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    for (int i = 0; i < N; i++) begin
      mem[16'h0100 + i] = 16'h0100 + 16'(i);
      mem[16'h0200 + i] = 16'h0200 + 16'(i);
    end
    rst_n = 1'b0; start = 1'b0; base_a = '0; base_b = '0;
    opcode_in = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    checkResetOutputs("reset");
    rst_n = 1'b1;

    $display("[TB] basic load");
    applyStimulus(16'h0100, 16'h0200, 3'b010, 0, 1'b0);
    $display("[TB] out_ready held low for 10 cycles");
    applyStimulus(16'h0100, 16'h0200, 3'b010, 10, 1'b0);
    $display("[TB] address wrap");
    applyStimulus(16'hFFFA, 16'h0200, 3'b011, 0, 1'b0);
    $display("[TB] start pulsed mid-fetch");
    applyStimulus(16'h0100, 16'h0200, 3'b010, 2, 1'b1);
    $display("[TB] reset mid-fetch");
    resetMidFetch(16'h0100, 16'h0200);
    applyStimulus(16'h0100, 16'h0200, 3'b001, 0, 1'b0);
    $display("[TB] random loads");
    for (int r = 0; r < 4; r++)
      applyStimulus(16'($urandom), 16'($urandom), 3'($urandom),
                    int'($urandom_range(0, 3)), 1'($urandom));
    $display("[TB] back-to-back loads");
    backToBack(16'($urandom), 16'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule

// File: doc/vec_operand_loader.md
# vec_operand_loader

Sequential operand-fetch stage placed directly upstream of the vector ALU (`alu_vec`). On a start command it reads two vectors, A and B, one element per cycle from a synchronous element-wide data memory. It assembles them into `vector_size`-bit registers and presents them with the latched opcode under a valid/ready handshake. The ALU consumes `vectorA`, `vectorB` and `opcode` combinationally while `out_valid` is high.

## Interface
- `vector_size`, 256, total vector width in bits
- `element`, 16, element width in bits; N = `vector_size`/`element` elements (16 by default)
- `addr_width`, 16, memory element-address width

- `clk` input 1: single clock, rising edge
- `rst_n` input 1: reset, asynchronous, active-low
- `start` input 1: load request, sampled only in IDLE
- `base_a` input `addr_width`: element address of A element 0
- `base_b` input `addr_width`: element address of B element 0
- `opcode_in` input 3: ALU opcode, latched on accepted start
- `busy` output 1: state != IDLE
- `mem_rd_en` output 1: memory read strobe
- `mem_addr` output `addr_width`: memory read address
- `mem_rdata` input `element`: read data, valid exactly 1 cycle after its `mem_rd_en`
- `vectorA` output `vector_size`: assembled vector A
- `vectorB` output `vector_size`: assembled vector B
- `opcode` output 3: latched opcode
- `out_valid` output 1: vectors and opcode complete and stable
- `out_ready` input 1: ALU/writeback accepts the result

## Operation
- FSM states: IDLE, FETCH, WAIT, DONE.
- IDLE to FETCH on `start`:
  - latch `base_a`, `base_b` and `opcode_in`
  - clear issue counter `cnt` (log2(2N) bits)
- FETCH: `mem_rd_en`=1 every cycle.
  - `mem_addr` = base_a + cnt for cnt < N, else base_b + (cnt − N).
  - Addition is modulo 2^`addr_width`, so addresses wrap past all-ones.
  - `cnt` increments each cycle. After issuing cnt = 2N−1, go to WAIT.
- Capture: a 1-cycle delayed copy of (rd_en, cnt) selects the destination slot.
  - Index k < N: `mem_rdata` is written to `vectorA[k*element +: element]`.
  - Index k ≥ N: `mem_rdata` is written to `vectorB[(k−N)*element +: element]`.
  - Element 0 occupies the LSBs.
- WAIT: `mem_rd_en`=0. The last element (B[N−1]) is captured, then go to DONE.
- DONE: `out_valid`=1. `vectorA`, `vectorB` and `opcode` are held constant.
  - `out_valid` && `out_ready` at an edge: go to IDLE.
  - `out_valid` never drops without a handshake.
- IDLE: vectors and opcode keep their last values; `out_valid`=0.
- `start` in any state other than IDLE is ignored (not queued).
- `start` is not accepted on the same edge as the DONE handshake; it needs one cycle in IDLE.
- Reset, asserted at any time including mid-FETCH: immediately return to IDLE and clear all registers. No partial result is ever presented.

## Timing
- Reset values:
  - `busy`, `mem_rd_en`, `out_valid` = 0
  - `mem_addr` = 0, `opcode` = 0
  - `vectorA`, `vectorB` = 0
- `start` accepted at edge E0:
  - `mem_rd_en` is high for 2N cycles, from after E0 to edge E0+2N.
  - Element k is issued in the cycle after E0+k and captured at E0+k+2.
  - `out_valid` rises after edge E0+2N+1, i.e. 33 cycles with N = 16.
- Handshake at edge H: `out_valid` is low after H. The earliest next `start` acceptance is edge H+1.
- Back-to-back throughput: one vector pair per 2N+3 cycles, with `out_ready` tied high.
- `mem_rdata` is ignored in every cycle not following a `mem_rd_en` cycle.

## Structure
- Shared package `vec_pkg`:
  - `VEC_SIZE`, `ELEM`, `N_ELEM` constants
  - `vec_t` typedef (logic [VEC_SIZE-1:0])
  - `loader_state_t` enum {IDLE, FETCH, WAIT, DONE}
- Single module; no sub-module is warranted. The datapath is one counter, one delayed index register and two slot-write decoders.
- Top-level integration: `vectorA`, `vectorB` and `opcode` wire directly to `alu_vec`.

## Test plan
- Memory holds addr i = 16'h0100+i at 0x0100..0x010F and 16'h0200+i at 0x0200..0x020F. Start with base_a=0x0100, base_b=0x0200, opcode_in=3'b010.
  - Required: out_valid rises 33 cycles after E0.
  - Required: `vectorA` slot i = 16'h0100+i and `vectorB` slot i = 16'h0200+i.
  - Required: `opcode` = 3'b010.
- Same load with `out_ready` held low for 10 cycles.
  - Required: `out_valid` and the vectors stay stable for all 10 cycles.
  - Required: IDLE one cycle after `out_ready` rises.
- base_a=0xFFFA.
  - Required: `mem_addr` sequence FFFA..FFFF, then 0000..0009, with no out-of-order capture.
- Pulse `start` mid-FETCH with different bases.
  - Required: ignored; the original result is presented unchanged.
- Assert `rst_n`=0 at cycle 10 of FETCH.
  - Required: all outputs 0 within the same cycle; IDLE.
  - Required: the next load completes correctly.
- Two back-to-back loads, `out_ready`=1, start held high.
  - Required: second FETCH begins one cycle after the first handshake.
  - Required: 35-cycle spacing between `out_valid` pulses.
